// File: rtl/xgriscv_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xgriscv_divider_pkg
//  Description : Shared definitions for the iterative RV32M divider.
//                Holds the operation encodings (as seen on the op port), the
//                FSM state encodings and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package xgriscv_divider_pkg;

    // Operation encoding: bit 1 selects remainder, bit 0 selects unsigned.
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_CALC = 2'b01,
        DIV_ST_FIX  = 2'b10
    } div_state_e;

    function automatic logic div_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage : xgriscv_divider_pkg
`default_nettype wire

// File: rtl/xgriscv_divider_abs_neg.sv
`default_nettype none
// ============================================================================
//  Module      : xgriscv_divider_abs_neg
//  Description : Combinational conditional two's-complement negator. Used
//                to take operand magnitudes at capture time and to restore
//                the result sign during fix-up.
//  Ports       : i_value [WIDTH] value to process
//                i_neg           1 = negate, 0 = pass through
//                o_value [WIDTH] processed value
//  Revision    : 1.0 - initial release
// ============================================================================
module xgriscv_divider_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_neg ? (~i_value + WIDTH'(1)) : i_value;

endmodule : xgriscv_divider_abs_neg
`default_nettype wire

// File: rtl/xgriscv_divider.sv
`default_nettype none
// ============================================================================
//  Module      : xgriscv_divider
//  Description : Iterative radix-2 restoring divider for RV32M DIV, DIVU,
//                REM and REMU. One quotient bit per cycle, start/done
//                handshake, flush abort, single-cycle fast paths for
//                divide-by-zero and signed overflow.
//  Ports       : clk          core clock, rising edge
//                rstn         asynchronous active-low reset
//                start        request, sampled in IDLE only
//                op [2]       00 DIV, 01 DIVU, 10 REM, 11 REMU
//                a, b [XLEN]  dividend, divisor
//                flush        abort current operation
//                busy         operation in flight
//                done         one-cycle result-valid pulse
//                result [XLEN] quotient or remainder, held until next done
//  Revision    : 1.0 - initial release
// ============================================================================
module xgriscv_divider
    import xgriscv_divider_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_e        state_q, state_d;
    logic [CNTW-1:0]   counter_q, counter_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   bmag_q, bmag_d;
    logic [1:0]        op_q, op_d;
    logic              quo_neg_q, quo_neg_d;
    logic              rem_neg_q, rem_neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              w_signed_in;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_b_zero;
    logic              w_ovf;
    logic [XLEN:0]     w_rem_sh;
    logic              w_geq;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_fix_in;
    logic              w_fix_neg;
    logic [XLEN-1:0]   w_fix_out;

    assign w_signed_in = div_is_signed(op);
    assign w_b_zero    = (b == '0);
    assign w_ovf       = w_signed_in && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == {XLEN{1'b1}});

    xgriscv_divider_abs_neg #(.WIDTH(XLEN)) u_abs_a (
        .i_value (a),
        .i_neg   (w_signed_in & a[XLEN-1]),
        .o_value (w_a_mag)
    );

    xgriscv_divider_abs_neg #(.WIDTH(XLEN)) u_abs_b (
        .i_value (b),
        .i_neg   (w_signed_in & b[XLEN-1]),
        .o_value (w_b_mag)
    );

    // Shifted partial remainder needs XLEN+1 bits: rem < |b| <= 2^XLEN-1,
    // so after the shift it can exceed XLEN bits. When it is >= |b| the
    // difference is again below |b| and fits back into XLEN bits.
    assign w_rem_sh = {rem_q, quo_q[XLEN-1]};
    assign w_geq    = (w_rem_sh >= {1'b0, bmag_q});
    assign w_diff   = w_rem_sh[XLEN-1:0] - bmag_q;

    assign w_fix_in  = div_is_rem(op_q) ? rem_q : quo_q;
    assign w_fix_neg = div_is_signed(op_q) & (div_is_rem(op_q) ? rem_neg_q : quo_neg_q);

    xgriscv_divider_abs_neg #(.WIDTH(XLEN)) u_fix (
        .i_value (w_fix_in),
        .i_neg   (w_fix_neg),
        .o_value (w_fix_out)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        bmag_d    = bmag_q;
        op_d      = op_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            DIV_ST_IDLE: begin
                if (start && !flush) begin
                    op_d = op;
                    if (w_b_zero) begin
                        done_d   = 1'b1;
                        result_d = div_is_rem(op) ? a : {XLEN{1'b1}};
                    end else if (w_ovf) begin
                        done_d   = 1'b1;
                        result_d = div_is_rem(op) ? '0 : a;
                    end else begin
                        rem_d     = '0;
                        quo_d     = w_a_mag;
                        bmag_d    = w_b_mag;
                        quo_neg_d = w_signed_in & (a[XLEN-1] ^ b[XLEN-1]);
                        rem_neg_d = w_signed_in & a[XLEN-1];
                        counter_d = CNTW'(XLEN);
                        busy_d    = 1'b1;
                        state_d   = DIV_ST_CALC;
                    end
                end
            end
            DIV_ST_CALC: begin
                rem_d     = w_geq ? w_diff : w_rem_sh[XLEN-1:0];
                quo_d     = {quo_q[XLEN-2:0], w_geq};
                counter_d = counter_q - CNTW'(1);
                if (counter_q == CNTW'(1)) begin
                    state_d = DIV_ST_FIX;
                end
            end
            DIV_ST_FIX: begin
                result_d = w_fix_out;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = DIV_ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = DIV_ST_IDLE;
            end
        endcase

        // Flush overrides everything, including a completion on the FIX edge.
        if (flush) begin
            state_d  = DIV_ST_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= DIV_ST_IDLE;
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bmag_q    <= '0;
            op_q      <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            bmag_q    <= bmag_d;
            op_q      <= op_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule : xgriscv_divider
`default_nettype wire

// File: tb/tb_xgriscv_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xgriscv_divider
//  Description : Self-checking bench for xgriscv_divider. Directed cases
//                plus randomized operations checked against an arithmetic
//                reference of the RISC-V division rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xgriscv_divider;

    localparam int C_XLEN     = 32;
    localparam int C_NORM_LAT = C_XLEN + 2;

    logic              clk;
    logic              rstn;
    logic              start;
    logic [1:0]        op;
    logic [C_XLEN-1:0] a;
    logic [C_XLEN-1:0] b;
    logic              flush;
    logic              busy;
    logic              done;
    logic [C_XLEN-1:0] result;

    int n_checks;
    int n_fail;

    xgriscv_divider #(.XLEN(C_XLEN), .CNTW(6)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V division semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        logic [31:0] r;
        sx = x;
        sy = y;
        if (y == 32'd0) begin
            r = o[1] ? x : 32'hFFFF_FFFF;
        end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            r = o[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            case (o)
                2'b00:   r = sx / sy;
                2'b01:   r = x / y;
                2'b10:   r = sx % sy;
                default: r = x % y;
            endcase
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return C_NORM_LAT;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles (cycle 1 = first after acceptance) until done; 0 on timeout.
    task automatic wait_done(output int lat, output logic busy_seen);
        lat       = 0;
        busy_seen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (busy) busy_seen = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
            step();
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int   lat;
        logic bs;
        int   exp_lat;
        issue(o, x, y);
        wait_done(lat, bs);
        exp_lat = ref_lat(o, x, y);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, result, ref_div(o, x, y));
        check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (exp_lat == 1) check_eq({tag, "_busy_seen"}, {31'd0, bs}, 32'd0);
        step();
        check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic watch_no_done(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            if (done) cnt++;
            step();
        end
        check_eq(tag, 32'(cnt), 32'd0);
    endtask

    initial begin
        int          lat;
        logic        bs;
        logic [31:0] held;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        n_checks = 0;
        n_fail   = 0;
        rstn  = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed arithmetic cases
        run_op("div_7_2",    2'b00, 32'd7, 32'd2);
        run_op("rem_7_2",    2'b10, 32'd7, 32'd2);
        run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);
        run_op("divu_5_0",   2'b01, 32'd5, 32'd0);
        run_op("remu_5_0",   2'b11, 32'd5, 32'd0);
        run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_m0_0",   2'b00, 32'hFFFF_FFF9, 32'd0);
        run_op("rem_m0_0",   2'b10, 32'hFFFF_FFF9, 32'd0);
        run_op("divu_big",   2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_op("remu_big",   2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_op("div_min_2",  2'b00, 32'h8000_0000, 32'd2);
        run_op("rem_7_m3",   2'b10, 32'd7, 32'hFFFF_FFFD);

        // Flush mid-calculation
        held = result;
        issue(2'b00, 32'd100, 32'd7);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_busy", {31'd0, busy}, 32'd0);
        watch_no_done("flush_no_done", 40);
        check_eq("flush_result_held", result, held);
        run_op("remu_after_flush", 2'b11, 32'd100, 32'd7);

        // Flush coinciding with the FIX edge
        held = result;
        issue(2'b00, 32'd1000, 32'd3);
        repeat (32) step();
        check_eq("fix_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("fix_flush_done", {31'd0, done}, 32'd0);
        check_eq("fix_flush_busy", {31'd0, busy}, 32'd0);
        watch_no_done("fix_flush_no_done", 5);
        check_eq("fix_flush_result", result, held);

        // Flush and start together in IDLE: nothing accepted
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd0;
        step();
        start = 1'b0;
        flush = 1'b0;
        check_eq("flush_start_busy", {31'd0, busy}, 32'd0);
        watch_no_done("flush_start_no_done", 5);

        // Start while busy is ignored
        issue(2'b00, 32'd100, 32'd7);
        repeat (4) step();
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd9;
        b     = 32'd4;
        step();
        start = 1'b0;
        wait_done(lat, bs);
        check_eq("busy_start_lat", 32'(lat), 32'(C_NORM_LAT - 5));
        check_eq("busy_start_res", result, 32'd14);
        step();
        watch_no_done("busy_start_no_queue", 40);

        // Asynchronous reset mid-operation
        run_op("pre_reset", 2'b01, 32'd1000, 32'd3);
        issue(2'b00, 32'd1000, 32'd3);
        repeat (14) step();
        rstn = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_result", result, 32'd0);
        #1;
        rstn = 1'b1;
        watch_no_done("arst_no_done", 40);

        // Back-to-back: second start issued in the done cycle
        issue(2'b00, 32'd7, 32'd2);
        wait_done(lat, bs);
        check_eq("b2b_first_lat", 32'(lat), 32'(C_NORM_LAT));
        check_eq("b2b_first_res", result, 32'd3);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'hFFFF_FFF9;
        b     = 32'd2;
        step();
        start = 1'b0;
        wait_done(lat, bs);
        check_eq("b2b_second_lat", 32'(lat), 32'(C_NORM_LAT));
        check_eq("b2b_second_res", result, 32'hFFFF_FFFF);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                2: ry = 32'($urandom_range(1, 17));
                3: ry = ~32'($urandom_range(0, 17));
                4: rx = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op("rand", ro, rx, ry);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_xgriscv_divider
`default_nettype wire
